axis_palette_loader: RTL and testbench

- Streams a new 256-entry palette from an AXI4-Stream source, such as a DMA or PS mailbox, into the inactive bank of the double-banked palette LUT RAM.
- Writes go through the RAM's BRAM-style write port.
- Once the load is complete, the active bank flips at the next video start-of-frame, so the palette never changes mid-frame.
- Sits beside the palette LUT datapath: it drives the LUT RAM write port and supplies the bank-select bit that the lookup path uses as its upper read-address bit.

---
 rtl/axis_palette_loader.sv | 122 ++++++++++++
 tb/tb_axis_palette_loader.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_palette_loader.sv
// Loads a palette from an AXI4-Stream source into the inactive bank of a double-banked LUT RAM.
// The bank select flips only at the video start-of-frame that follows a complete, correct load.
//
// state    | meaning
// IDLE     | waiting for entry 0 of a new palette
// LOAD     | accepting entries 1..PALETTE_DEPTH-1
// WAIT_SOF | palette complete, stream stalled until the next sof swaps banks
// DRAIN    | over-long palette, discarding beats up to tlast
module axis_palette_loader #(
  parameter int PALETTE_DEPTH = 256,
  parameter int BANK_BITS     = 1
) (
  input  logic        axis_aclk,
  input  logic        axis_aresetn,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  input  logic        sof,
  output logic        lut_ram_en,
  output logic [3:0]  lut_ram_we,
  output logic [31:0] lut_ram_addr,
  output logic [31:0] lut_ram_wdata,
  output logic        active_bank,
  output logic        load_busy,
  output logic        load_done,
  output logic        load_err
);

  localparam int IDX_W = $clog2(PALETTE_DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PALETTE_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_SOF, DRAIN} state_t;

  state_t               state, state_nx;
  logic [IDX_W-1:0]     idx, idx_nx;
  logic                 wr_nx, err_nx, swap_nx;
  logic                 accept;
  logic [BANK_BITS-1:0] tgt_bank;
  logic [31:0]          wr_addr;

  assign accept   = s_axis_tvalid & s_axis_tready;
  assign tgt_bank = BANK_BITS'(~active_bank);
  assign wr_addr  = 32'({tgt_bank, idx}) << 2;

  // idx is always 0 in IDLE, so IDLE and LOAD share the per-beat decision.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    wr_nx    = 1'b0;
    err_nx   = 1'b0;
    swap_nx  = 1'b0;
    case (state)
      IDLE, LOAD: begin
        if (accept) begin
          wr_nx = 1'b1;
          if (idx == LAST_IDX) begin
            idx_nx = '0;
            if (s_axis_tlast) begin
              state_nx = WAIT_SOF;
            end else begin
              err_nx   = 1'b1;
              state_nx = DRAIN;
            end
          end else if (s_axis_tlast) begin
            err_nx   = 1'b1;
            idx_nx   = '0;
            state_nx = IDLE;
          end else begin
            idx_nx   = idx + 1'b1;
            state_nx = LOAD;
          end
        end
      end
      WAIT_SOF: begin
        if (sof) begin
          swap_nx  = 1'b1;
          idx_nx   = '0;
          state_nx = IDLE;
        end
      end
      DRAIN: begin
        if (accept && s_axis_tlast) begin
          idx_nx   = '0;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state         <= IDLE;
      idx           <= '0;
      active_bank   <= 1'b0;
      s_axis_tready <= 1'b0;
      load_busy     <= 1'b0;
      load_done     <= 1'b0;
      load_err      <= 1'b0;
      lut_ram_en    <= 1'b0;
      lut_ram_we    <= 4'h0;
      lut_ram_addr  <= 32'h0;
      lut_ram_wdata <= 32'h0;
    end else begin
      state         <= state_nx;
      idx           <= idx_nx;
      active_bank   <= active_bank ^ swap_nx;
      s_axis_tready <= (state_nx != WAIT_SOF);
      load_busy     <= (state_nx != IDLE);
      load_done     <= swap_nx;
      load_err      <= err_nx;
      lut_ram_en    <= wr_nx;
      lut_ram_we    <= {4{wr_nx}};
      if (wr_nx) begin
        lut_ram_addr  <= wr_addr;
        lut_ram_wdata <= s_axis_tdata;
      end
    end
  end

endmodule

// File: tb/tb_axis_palette_loader.sv
// Directed bench for axis_palette_loader: full, gapped, short, long, sof-collision and reset loads.
module tb_axis_palette_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] s_axis_tdata = 32'h0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        s_axis_tlast = 1'b0;
  logic        sof = 1'b0;
  logic        lut_ram_en;
  logic [3:0]  lut_ram_we;
  logic [31:0] lut_ram_addr;
  logic [31:0] lut_ram_wdata;
  logic        active_bank;
  logic        load_busy;
  logic        load_done;
  logic        load_err;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  axis_palette_loader #(.PALETTE_DEPTH(256), .BANK_BITS(1)) dut (
    .axis_aclk     (clk),
    .axis_aresetn  (rst_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .sof           (sof),
    .lut_ram_en    (lut_ram_en),
    .lut_ram_we    (lut_ram_we),
    .lut_ram_addr  (lut_ram_addr),
    .lut_ram_wdata (lut_ram_wdata),
    .active_bank   (active_bank),
    .load_busy     (load_busy),
    .load_done     (load_done),
    .load_err      (load_err)
  );

  // One beat: present it, wait for tready, then check the registered write one cycle after the handshake.
  task automatic beat(input logic [31:0] d, input logic last, input logic exp_wr,
                      input logic [31:0] exp_addr, input logic exp_err);
    int n;
    n = 0;
    s_axis_tdata  = d;
    s_axis_tvalid = 1'b1;
    s_axis_tlast  = last;
    while (s_axis_tready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    vecs++;
    if (n >= 50) begin
      errs++;
      $display("FAIL beat_timeout data=%h tready=%b required 1", d, s_axis_tready);
    end
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    vecs++;
    if (lut_ram_en !== exp_wr) begin
      errs++;
      $display("FAIL ram_en data=%h got %b required %b", d, lut_ram_en, exp_wr);
    end
    if (exp_wr) begin
      vecs++;
      if (lut_ram_we !== 4'hF || lut_ram_addr !== exp_addr || lut_ram_wdata !== d) begin
        errs++;
        $display("FAIL ram_write got we=%h addr=%h wdata=%h required we=f addr=%h wdata=%h",
                 lut_ram_we, lut_ram_addr, lut_ram_wdata, exp_addr, d);
      end
    end else begin
      vecs++;
      if (lut_ram_we !== 4'h0) begin
        errs++;
        $display("FAIL ram_we_idle got %h required 0", lut_ram_we);
      end
    end
    vecs++;
    if (load_err !== exp_err) begin
      errs++;
      $display("FAIL load_err data=%h got %b required %b", d, load_err, exp_err);
    end
  endtask

  task automatic idle(input int cycles);
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk); #1;
      vecs++;
      if (lut_ram_en !== 1'b0 || load_err !== 1'b0) begin
        errs++;
        $display("FAIL idle_quiet got en=%b err=%b required 0 0", lut_ram_en, load_err);
      end
    end
  endtask

  task automatic sof_pulse(input logic exp_done, input logic exp_bank);
    sof = 1'b1;
    @(posedge clk); #1;
    sof = 1'b0;
    vecs++;
    if (load_done !== exp_done || active_bank !== exp_bank) begin
      errs++;
      $display("FAIL sof_swap got done=%b bank=%b required done=%b bank=%b",
               load_done, active_bank, exp_done, exp_bank);
    end
    @(posedge clk); #1;
    vecs++;
    if (load_done !== 1'b0 || load_busy !== 1'b0 || active_bank !== exp_bank || s_axis_tready !== 1'b1) begin
      errs++;
      $display("FAIL after_sof got done=%b busy=%b bank=%b tready=%b required 0 0 %b 1",
               load_done, load_busy, active_bank, s_axis_tready, exp_bank);
    end
  endtask

  task automatic check_all_zero(input string tag);
    vecs++;
    if (lut_ram_en !== 1'b0 || lut_ram_we !== 4'h0 || lut_ram_addr !== 32'h0 ||
        lut_ram_wdata !== 32'h0 || active_bank !== 1'b0 || load_busy !== 1'b0 ||
        load_done !== 1'b0 || load_err !== 1'b0 || s_axis_tready !== 1'b0) begin
      errs++;
      $display("FAIL %s got en=%b we=%h addr=%h wd=%h bank=%b busy=%b done=%b err=%b tready=%b required all 0",
               tag, lut_ram_en, lut_ram_we, lut_ram_addr, lut_ram_wdata, active_bank,
               load_busy, load_done, load_err, s_axis_tready);
    end
  endtask

  task automatic full_load(input logic [31:0] base, input logic bank, input logic gaps);
    logic [31:0] bank_off;
    bank_off = bank ? 32'h400 : 32'h0;
    for (int i = 0; i < 256; i++) begin
      beat(base + i, i == 255, 1'b1, bank_off + 32'(4 * i), 1'b0);
      if (gaps && (i % 7 == 3)) idle(i % 3 + 1);
    end
    vecs++;
    if (load_busy !== 1'b1 || s_axis_tready !== 1'b0 || active_bank !== ~bank) begin
      errs++;
      $display("FAIL load_complete got busy=%b tready=%b bank=%b required 1 0 %b",
               load_busy, s_axis_tready, active_bank, ~bank);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset_state");
    rst_n = 1'b1;
    @(posedge clk); #1;
    vecs++;
    if (s_axis_tready !== 1'b1 || load_busy !== 1'b0) begin
      errs++;
      $display("FAIL reset_release got tready=%b busy=%b required 1 0", s_axis_tready, load_busy);
    end
  endtask

  task automatic test_full_load();
    full_load(32'hA500_0000, 1'b1, 1'b0);
    idle(10);
    vecs++;
    if (active_bank !== 1'b0 || s_axis_tready !== 1'b0 || load_done !== 1'b0) begin
      errs++;
      $display("FAIL wait_sof_hold got bank=%b tready=%b done=%b required 0 0 0",
               active_bank, s_axis_tready, load_done);
    end
    sof_pulse(1'b1, 1'b1);
  endtask

  task automatic test_gapped_load();
    full_load(32'h5A00_0000, 1'b0, 1'b1);
    idle(3);
    sof_pulse(1'b1, 1'b0);
  endtask

  task automatic test_short_load();
    for (int i = 0; i < 100; i++)
      beat(32'hC300_0000 + i, i == 99, 1'b1, 32'h400 + 32'(4 * i), i == 99);
    vecs++;
    if (load_busy !== 1'b0 || s_axis_tready !== 1'b1) begin
      errs++;
      $display("FAIL short_idle got busy=%b tready=%b required 0 1", load_busy, s_axis_tready);
    end
    sof_pulse(1'b0, 1'b0);
  endtask

  task automatic test_long_load();
    for (int i = 0; i < 300; i++) begin
      beat(32'hD000_0000 + i, i == 299, i <= 255, 32'h400 + 32'(4 * i), i == 255);
      if (i == 256) begin
        vecs++;
        if (load_busy !== 1'b1 || s_axis_tready !== 1'b1) begin
          errs++;
          $display("FAIL drain_state got busy=%b tready=%b required 1 1", load_busy, s_axis_tready);
        end
      end
    end
    vecs++;
    if (load_busy !== 1'b0) begin
      errs++;
      $display("FAIL long_idle got busy=%b required 0", load_busy);
    end
    sof_pulse(1'b0, 1'b0);
  endtask

  task automatic test_sof_with_last();
    for (int i = 0; i < 256; i++) begin
      if (i == 255) sof = 1'b1;
      beat(32'h7700_0000 + i, i == 255, 1'b1, 32'h400 + 32'(4 * i), 1'b0);
      sof = 1'b0;
    end
    vecs++;
    if (active_bank !== 1'b0 || load_done !== 1'b0 || load_busy !== 1'b1 || s_axis_tready !== 1'b0) begin
      errs++;
      $display("FAIL sof_collision got bank=%b done=%b busy=%b tready=%b required 0 0 1 0",
               active_bank, load_done, load_busy, s_axis_tready);
    end
    idle(20);
    sof_pulse(1'b1, 1'b1);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i <= 128; i++)
      beat(32'h3300_0000 + i, 1'b0, 1'b1, 32'(4 * i), 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    full_load(32'hE100_0000, 1'b1, 1'b0);
    idle(2);
    sof_pulse(1'b1, 1'b1);
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_gapped_load();
    test_short_load();
    test_long_load();
    test_sof_with_last();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
